// File: rtl/sbinit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sbinit_pkg
// Description : Shared SBINIT message codes, FSM state encoding and defaults
//               for the SBINIT initiator and responder.
// Revision    : 1.0 - initial release
// ============================================================================
package sbinit_pkg;

    localparam int C_SB_MSG_WIDTH_DEFAULT = 4;

    // Sideband message codes carried on the encoded/decoded message buses
    localparam int OUT_OF_RESET = 3;
    localparam int DONE_REQ     = 1;
    localparam int DONE_RESP    = 2;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_WAIT_OOR      = 3'd1,
        ST_WAIT_DONE_REQ = 3'd2,
        ST_SEND_RESP     = 3'd3,
        ST_END           = 3'd4
    } sbinit_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/rx_sbinit_responder_if.sv
`default_nettype none
// ============================================================================
// Interface   : rx_sbinit_responder_if
// Description : LTSM/sideband-facing signals of the SBINIT responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_sbinit_responder_if #(
    parameter int SB_MSG_WIDTH = 4
);
    logic                    i_SBINIT_en;
    logic                    i_rx_msg_valid;
    logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg;
    logic                    i_falling_edge_busy;
    logic                    i_tx_valid;
    logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx;
    logic                    o_valid_rx;
    logic                    o_SBINIT_end_rx;
    logic                    o_SBINIT_timeout;

    // LTSM / sideband side
    modport master (
        output i_SBINIT_en, i_rx_msg_valid, i_decoded_SB_msg,
               i_falling_edge_busy, i_tx_valid,
        input  o_encoded_SB_msg_rx, o_valid_rx, o_SBINIT_end_rx,
               o_SBINIT_timeout
    );

    // Responder side
    modport slave (
        input  i_SBINIT_en, i_rx_msg_valid, i_decoded_SB_msg,
               i_falling_edge_busy, i_tx_valid,
        output o_encoded_SB_msg_rx, o_valid_rx, o_SBINIT_end_rx,
               o_SBINIT_timeout
    );
endinterface
`default_nettype wire

// File: rtl/sbinit_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sbinit_timeout_cnt
// Description : Enable/clear saturating counter; o_done flags the increment
//               that brings the count to LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module sbinit_timeout_cnt #(
    parameter int LIMIT = 8000,
    parameter int CNT_W = 13
) (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_done
);
    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // High in the cycle whose increment lands on LIMIT, so a registered
    // consumer sees its flag exactly LIMIT cycles after counting started
    assign o_done = i_en && !i_clr && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/rx_sbinit_responder.sv
`default_nettype none
// ============================================================================
// Module      : rx_sbinit_responder
// Description : Responder half of the sideband SBINIT handshake; waits for
//               Out-of-Reset and done_req, answers with done_resp.
//               Optional timeout built when SBINIT_RX_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_sbinit_responder
    import sbinit_pkg::*;
#(
    parameter int SB_MSG_WIDTH   = sbinit_pkg::C_SB_MSG_WIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = 8000,
    parameter int TIMEOUT_CNT_W  = 13
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    rx_sbinit_responder_if.slave  rx
);
    if ((2 ** TIMEOUT_CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
        $error("TIMEOUT_CNT_W too narrow for TIMEOUT_CYCLES");
    end

    sbinit_rx_state_t        r_state;
    logic [SB_MSG_WIDTH-1:0] r_msg;
    logic                    r_valid;
    logic                    r_end;
    logic                    w_hold;
    logic                    w_oor_rx;
    logic                    w_done_req_rx;
    logic                    w_clr_valid;

    assign w_oor_rx      = rx.i_rx_msg_valid &&
                           (rx.i_decoded_SB_msg == SB_MSG_WIDTH'(OUT_OF_RESET));
    assign w_done_req_rx = rx.i_rx_msg_valid &&
                           (rx.i_decoded_SB_msg == SB_MSG_WIDTH'(DONE_REQ));
    // A busy edge while the initiator drives valid belongs to its message
    assign w_clr_valid   = rx.i_falling_edge_busy && !rx.i_tx_valid;

`ifdef SBINIT_RX_TIMEOUT_EN
    logic r_timeout;
    logic w_cnt_clr;
    logic w_cnt_en;
    logic w_cnt_done;

    assign w_cnt_clr = !rx.i_SBINIT_en || (r_state == ST_IDLE);
    assign w_cnt_en  = (r_state == ST_WAIT_OOR) ||
                       (r_state == ST_WAIT_DONE_REQ) ||
                       (r_state == ST_SEND_RESP);

    sbinit_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (TIMEOUT_CNT_W)
    ) u_timeout_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_done  (w_cnt_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timeout <= 1'b0;
        end else if (w_cnt_clr) begin
            r_timeout <= 1'b0;
        end else if (w_cnt_done) begin
            r_timeout <= 1'b1;
        end
    end

    assign w_hold              = r_timeout;
    assign rx.o_SBINIT_timeout = r_timeout;
`else
    assign w_hold              = 1'b0;
    assign rx.o_SBINIT_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_msg   <= '0;
            r_valid <= 1'b0;
            r_end   <= 1'b0;
        end else if (!rx.i_SBINIT_en) begin
            // Abandon any pending response, even mid-transmission
            r_state <= ST_IDLE;
            r_msg   <= '0;
            r_valid <= 1'b0;
            r_end   <= 1'b0;
        end else begin
            if (w_clr_valid && !w_hold) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_msg   <= '0;
                    r_valid <= 1'b0;
                    r_end   <= 1'b0;
                    r_state <= ST_WAIT_OOR;
                end
                ST_WAIT_OOR: begin
                    if (!w_hold && w_oor_rx) begin
                        r_state <= ST_WAIT_DONE_REQ;
                    end
                end
                ST_WAIT_DONE_REQ: begin
                    // Placed after the clear so a same-cycle set wins
                    if (!w_hold && w_done_req_rx) begin
                        r_state <= ST_SEND_RESP;
                        r_msg   <= SB_MSG_WIDTH'(DONE_RESP);
                        r_valid <= 1'b1;
                    end
                end
                ST_SEND_RESP: begin
                    if (!w_hold && r_valid && w_clr_valid) begin
                        r_state <= ST_END;
                        r_end   <= 1'b1;
                    end
                end
                ST_END: begin
                    r_end <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx.o_encoded_SB_msg_rx = r_msg;
    assign rx.o_valid_rx          = r_valid;
    assign rx.o_SBINIT_end_rx     = r_end;

endmodule
`default_nettype wire
